// File: rtl/urv_dm_wb_bridge_pkg.sv
// Shared types and software-visible constants for the uRV data-memory Wishbone bridge.
// The error-data word lives here so firmware-visible values stay in one place.
package urv_dm_wb_bridge_pkg;

    localparam logic [31:0] URV_DM_ERR_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } dm_state_e;

    // Watchdog width: just wide enough for the timeout, clamped to 8..16 bits.
    function automatic int wdog_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        if (w < 8) begin
            w = 8;
        end else if (w > 16) begin
            w = 16;
        end
        return w;
    endfunction

endpackage

// File: rtl/urv_dm_wb_bridge.sv
// uRV data-memory port to pipelined Wishbone B4 master: one bus transaction per
// load/store pulse, registered done pulses, sticky error flags and a bus watchdog.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transaction; a load/store pulse starts one
// REQ     | cyc=1 stb=1, waiting for the slave to drop stall
// WAIT    | cyc=1 stb=0, waiting for ack/err (or watchdog expiry)
module urv_dm_wb_bridge
    import urv_dm_wb_bridge_pkg::*;
#(
    parameter int          g_timeout  = 255,
    parameter logic [31:0] g_err_data = URV_DM_ERR_DATA
) (
    input  logic        clk_i,
    input  logic        rst_n_i,

    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_data_s_i,
    input  logic [3:0]  dm_data_select_i,
    input  logic        dm_store_i,
    input  logic        dm_load_i,
    output logic [31:0] dm_data_l_o,
    output logic        dm_load_done_o,
    output logic        dm_store_done_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i,
    input  logic        wb_stall_i,

    output logic        bus_err_o,
    output logic        proto_err_o,
    output logic [31:0] err_addr_o,
    input  logic        err_clr_i
);

    localparam int            CW        = wdog_width(g_timeout);
    localparam logic [CW-1:0] WDOG_LOAD = CW'(g_timeout);
    localparam bit            WDOG_EN   = (g_timeout != 0);

    dm_state_e     state;
    logic [CW-1:0] wdog_cnt;

    logic busy;
    logic req_any;
    logic tmo;
    logic done_now;
    logic fail_now;
    logic proto_set;

    assign busy    = (state != ST_IDLE);
    assign req_any = dm_load_i | dm_store_i;

    // Down-counter loaded with the timeout; expiry when the edge would take it to zero,
    // which is the edge where an up-count from zero would reach g_timeout.
    assign tmo = WDOG_EN && (wdog_cnt == CW'(1));

    assign done_now  = busy & (wb_ack_i | wb_err_i | tmo);
    assign fail_now  = busy & (wb_err_i | (tmo & ~wb_ack_i));
    assign proto_set = (~busy & dm_load_i & dm_store_i) | (busy & req_any);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state           <= ST_IDLE;
            wdog_cnt        <= '0;
            wb_cyc_o        <= 1'b0;
            wb_stb_o        <= 1'b0;
            wb_we_o         <= 1'b0;
            wb_adr_o        <= '0;
            wb_dat_o        <= '0;
            wb_sel_o        <= '0;
            dm_data_l_o     <= '0;
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;
            bus_err_o       <= 1'b0;
            proto_err_o     <= 1'b0;
            err_addr_o      <= '0;
        end else begin
            dm_load_done_o  <= 1'b0;
            dm_store_done_o <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (req_any) begin
                        wb_cyc_o <= 1'b1;
                        wb_stb_o <= 1'b1;
                        wb_we_o  <= dm_store_i;
                        wb_adr_o <= dm_addr_i;
                        wb_dat_o <= dm_data_s_i;
                        wb_sel_o <= dm_data_select_i;
                        wdog_cnt <= WDOG_LOAD;
                        state    <= ST_REQ;
                    end
                end

                ST_REQ, ST_WAIT: begin
                    if (done_now) begin
                        wb_cyc_o <= 1'b0;
                        wb_stb_o <= 1'b0;
                        state    <= ST_IDLE;
                        if (wb_we_o) begin
                            dm_store_done_o <= 1'b1;
                        end else begin
                            dm_load_done_o <= 1'b1;
                            dm_data_l_o    <= fail_now ? g_err_data : wb_dat_i;
                        end
                    end else begin
                        if (WDOG_EN) begin
                            wdog_cnt <= wdog_cnt - CW'(1);
                        end
                        if (state == ST_REQ && !wb_stall_i) begin
                            wb_stb_o <= 1'b0;
                            state    <= ST_WAIT;
                        end
                    end
                end

                default: begin
                    wb_cyc_o <= 1'b0;
                    wb_stb_o <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase

            // A clear in the same cycle as a new error wins; that error is lost.
            if (err_clr_i) begin
                bus_err_o   <= 1'b0;
                proto_err_o <= 1'b0;
                err_addr_o  <= '0;
            end else begin
                if (fail_now) begin
                    bus_err_o <= 1'b1;
                    if (!bus_err_o) begin
                        err_addr_o <= wb_adr_o;
                    end
                end
                if (proto_set) begin
                    proto_err_o <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_urv_dm_wb_bridge.sv
// Self-checking bench for urv_dm_wb_bridge: behavioural Wishbone slave, done-pulse
// scoreboard, and one task per scenario.
module tb_urv_dm_wb_bridge;

    localparam int TB_TIMEOUT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] dm_addr_i = '0;
    logic [31:0] dm_data_s_i = '0;
    logic [3:0]  dm_data_select_i = '0;
    logic        dm_store_i = 1'b0;
    logic        dm_load_i = 1'b0;
    logic [31:0] dm_data_l_o;
    logic        dm_load_done_o;
    logic        dm_store_done_o;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [31:0] wb_adr_o, wb_dat_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_stall_i = 1'b0;
    logic        bus_err_o, proto_err_o;
    logic [31:0] err_addr_o;
    logic        err_clr_i = 1'b0;

    urv_dm_wb_bridge #(
        .g_timeout (TB_TIMEOUT),
        .g_err_data(32'hDEADBEEF)
    ) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .dm_addr_i       (dm_addr_i),
        .dm_data_s_i     (dm_data_s_i),
        .dm_data_select_i(dm_data_select_i),
        .dm_store_i      (dm_store_i),
        .dm_load_i       (dm_load_i),
        .dm_data_l_o     (dm_data_l_o),
        .dm_load_done_o  (dm_load_done_o),
        .dm_store_done_o (dm_store_done_o),
        .wb_cyc_o        (wb_cyc_o),
        .wb_stb_o        (wb_stb_o),
        .wb_we_o         (wb_we_o),
        .wb_adr_o        (wb_adr_o),
        .wb_dat_o        (wb_dat_o),
        .wb_sel_o        (wb_sel_o),
        .wb_dat_i        (wb_dat_i),
        .wb_ack_i        (wb_ack_i),
        .wb_err_i        (wb_err_i),
        .wb_stall_i      (wb_stall_i),
        .bus_err_o       (bus_err_o),
        .proto_err_o     (proto_err_o),
        .err_addr_o      (err_addr_o),
        .err_clr_i       (err_clr_i)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_load;
        logic [31:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Slave: stalls for stall_left cycles, then answers one cycle after acceptance.
    // resp_mode 0 = ack, 1 = err, 2 = never answer.
    int stall_left = 0;
    int resp_mode = 0;
    bit accepted = 1'b0;

    always @(posedge clk) begin
        #1;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        if (accepted) begin
            if (resp_mode == 0) wb_ack_i = 1'b1;
            else if (resp_mode == 1) wb_err_i = 1'b1;
            accepted = 1'b0;
        end
        wb_stall_i = 1'b0;
        if (rst_n && wb_cyc_o && wb_stb_o) begin
            if (stall_left > 0) begin
                wb_stall_i = 1'b1;
                stall_left--;
            end else begin
                accepted = 1'b1;
            end
        end
    end

    // Scoreboard: every done pulse must match the oldest expected completion.
    always @(negedge clk) begin
        if (rst_n && (dm_load_done_o || dm_store_done_o)) begin
            checks++;
            if (dm_load_done_o && dm_store_done_o) begin
                errors++;
                $display("FAIL done_exclusive: load_done=%0b store_done=%0b, required not both", dm_load_done_o, dm_store_done_o);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: done pulse (load=%0b) with nothing expected", dm_load_done_o);
            end else begin
                mon_e = sb.pop_front();
                if (dm_load_done_o !== mon_e.is_load || (mon_e.is_load && dm_data_l_o !== mon_e.data)) begin
                    errors++;
                    $display("FAIL sb_done: got load=%0b data=%h, required load=%0b data=%h", dm_load_done_o, dm_data_l_o, mon_e.is_load, mon_e.data);
                end
            end
        end
    end

    // Call at a negedge; returns at the negedge inside the first request cycle.
    task automatic drive_req(input bit ld, input bit st, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        dm_load_i = ld;
        dm_store_i = st;
        dm_addr_i = a;
        dm_data_s_i = d;
        dm_data_select_i = s;
        @(negedge clk);
        dm_load_i = 1'b0;
        dm_store_i = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int stb_n, output int cyc_n);
        lat = -1;
        stb_n = 0;
        cyc_n = 0;
        for (int k = 0; k < 50; k++) begin
            if (wb_stb_o) stb_n++;
            if (wb_cyc_o) cyc_n++;
            if (dm_load_done_o || dm_store_done_o) begin
                lat = k;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({dm_data_l_o, dm_load_done_o, dm_store_done_o, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o,
             wb_dat_o, wb_sel_o, bus_err_o, proto_err_o, err_addr_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: cyc=%0b stb=%0b adr=%h bus_err=%0b proto=%0b, required all 0", wb_cyc_o, wb_stb_o, wb_adr_o, bus_err_o, proto_err_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_zero_wait();
        int lat, sn, cn;
        resp_mode = 0;
        wb_dat_i = 32'h12345678;
        sb.push_back('{1'b1, 32'h12345678});
        drive_req(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        checks++;
        if (wb_adr_o !== 32'h100 || wb_we_o !== 1'b0 || wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1) begin
            errors++;
            $display("FAIL load_bus: adr=%h we=%0b cyc=%0b stb=%0b, required 100 0 1 1", wb_adr_o, wb_we_o, wb_cyc_o, wb_stb_o);
        end
        wait_done(lat, sn, cn);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL load_latency: got %0d, required 2", lat);
        end
        @(negedge clk);
        wb_dat_i = 32'h0;
        checks++;
        if (dm_load_done_o !== 1'b0 || dm_data_l_o !== 32'h12345678) begin
            errors++;
            $display("FAIL load_hold: done=%0b data=%h, required 0 12345678", dm_load_done_o, dm_data_l_o);
        end
    endtask

    task automatic test_store_stall();
        int lat, sn, cn;
        resp_mode = 0;
        stall_left = 3;
        sb.push_back('{1'b0, 32'h0});
        drive_req(1'b0, 1'b1, 32'h204, 32'hA5A5A5A5, 4'b0011);
        checks++;
        if (wb_sel_o !== 4'b0011 || wb_we_o !== 1'b1 || wb_dat_o !== 32'hA5A5A5A5 || wb_adr_o !== 32'h204) begin
            errors++;
            $display("FAIL store_bus: sel=%b we=%0b dat=%h adr=%h, required 0011 1 a5a5a5a5 204", wb_sel_o, wb_we_o, wb_dat_o, wb_adr_o);
        end
        wait_done(lat, sn, cn);
        checks++;
        if (sn !== 4 || lat !== 5) begin
            errors++;
            $display("FAIL store_stall: stb_cycles=%0d latency=%0d, required 4 5", sn, lat);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int lat, sn, cn;
        resp_mode = 0;
        sb.push_back('{1'b0, 32'h0});
        drive_req(1'b0, 1'b1, 32'h10, 32'h55AA55AA, 4'hF);
        wait_done(lat, sn, cn);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL b2b_first_latency: got %0d, required 2", lat);
        end
        wb_dat_i = 32'hCAFEF00D;
        sb.push_back('{1'b1, 32'hCAFEF00D});
        drive_req(1'b1, 1'b0, 32'h14, 32'h0, 4'hF);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_adr_o !== 32'h14 || wb_we_o !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_gap: cyc=%0b stb=%0b adr=%h we=%0b, required 1 1 14 0", wb_cyc_o, wb_stb_o, wb_adr_o, wb_we_o);
        end
        wait_done(lat, sn, cn);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL b2b_second_latency: got %0d, required 2", lat);
        end
        @(negedge clk);
    endtask

    task automatic test_error();
        int lat, sn, cn;
        resp_mode = 1;
        wb_dat_i = 32'h01020304;
        sb.push_back('{1'b1, 32'hDEADBEEF});
        drive_req(1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        wait_done(lat, sn, cn);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL err_latency: got %0d, required 2", lat);
        end
        @(negedge clk);
        checks++;
        if (bus_err_o !== 1'b1 || err_addr_o !== 32'h300 || proto_err_o !== 1'b0) begin
            errors++;
            $display("FAIL err_flags: bus_err=%0b err_addr=%h proto=%0b, required 1 300 0", bus_err_o, err_addr_o, proto_err_o);
        end
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        checks++;
        if (bus_err_o !== 1'b0 || proto_err_o !== 1'b0 || err_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL err_clear: bus_err=%0b proto=%0b err_addr=%h, required 0 0 0", bus_err_o, proto_err_o, err_addr_o);
        end
        resp_mode = 0;
    endtask

    task automatic test_timeout();
        int lat, cn;
        bit we_seen;
        bit adr_moved;
        resp_mode = 2;
        lat = -1;
        cn = 0;
        we_seen = 1'b0;
        adr_moved = 1'b0;
        sb.push_back('{1'b1, 32'hDEADBEEF});
        drive_req(1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
        for (int k = 0; k < 50; k++) begin
            if (wb_cyc_o) cn++;
            if (wb_we_o) we_seen = 1'b1;
            if (wb_adr_o !== 32'h500) adr_moved = 1'b1;
            if (dm_load_done_o || dm_store_done_o) begin
                lat = k;
                break;
            end
            dm_store_i = (k == 2);
            dm_addr_i = 32'h600;
            @(negedge clk);
        end
        dm_store_i = 1'b0;
        checks++;
        if (cn !== TB_TIMEOUT || lat !== TB_TIMEOUT) begin
            errors++;
            $display("FAIL timeout_abort: cyc_cycles=%0d done_at=%0d, required %0d %0d", cn, lat, TB_TIMEOUT, TB_TIMEOUT);
        end
        checks++;
        if (we_seen || adr_moved) begin
            errors++;
            $display("FAIL busy_request_ignored: we_seen=%0b adr_moved=%0b, required 0 0", we_seen, adr_moved);
        end
        @(negedge clk);
        checks++;
        if (bus_err_o !== 1'b1 || proto_err_o !== 1'b1 || err_addr_o !== 32'h500) begin
            errors++;
            $display("FAIL timeout_flags: bus_err=%0b proto=%0b err_addr=%h, required 1 1 500", bus_err_o, proto_err_o, err_addr_o);
        end
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
        resp_mode = 0;
    endtask

    task automatic test_both_req();
        int lat, sn, cn;
        resp_mode = 0;
        sb.push_back('{1'b0, 32'h0});
        drive_req(1'b1, 1'b1, 32'h400, 32'h11223344, 4'hF);
        checks++;
        if (wb_we_o !== 1'b1 || wb_dat_o !== 32'h11223344) begin
            errors++;
            $display("FAIL both_is_store: we=%0b dat=%h, required 1 11223344", wb_we_o, wb_dat_o);
        end
        wait_done(lat, sn, cn);
        @(negedge clk);
        checks++;
        if (lat !== 2 || proto_err_o !== 1'b1 || bus_err_o !== 1'b0) begin
            errors++;
            $display("FAIL both_flags: latency=%0d proto=%0b bus_err=%0b, required 2 1 0", lat, proto_err_o, bus_err_o);
        end
        err_clr_i = 1'b1;
        @(negedge clk);
        err_clr_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat, sn, cn;
        int dones;
        resp_mode = 2;
        dones = 0;
        drive_req(1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
        @(negedge clk);
        checks++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_wait: cyc=%0b stb=%0b, required 1 0", wb_cyc_o, wb_stb_o);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_async_drop: cyc=%0b stb=%0b, required 0 0", wb_cyc_o, wb_stb_o);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (dm_load_done_o || dm_store_done_o) dones++;
        end
        accepted = 1'b0;
        stall_left = 0;
        resp_mode = 0;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            if (dm_load_done_o || dm_store_done_o) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++;
            $display("FAIL rst_no_done: %0d done pulses, required 0", dones);
        end
        wb_dat_i = 32'h0BADF00D;
        sb.push_back('{1'b1, 32'h0BADF00D});
        drive_req(1'b1, 1'b0, 32'h704, 32'h0, 4'hF);
        wait_done(lat, sn, cn);
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL rst_fresh_load: latency=%0d, required 2", lat);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_load_zero_wait();
        test_store_stall();
        test_back_to_back();
        test_error();
        test_timeout();
        test_both_req();
        test_reset_mid();
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected completions never seen, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
